// File: rtl/regfile_rat.sv
// Architectural register file merged with the register status table.
// Each architectural register holds its committed value, a busy bit and the
// ROB tag of its youngest in-flight producer. Reads are combinational with a
// write-first bypass of the retiring value. Same-cycle renames stay invisible
// to readers, so a dispatching instruction sees its pre-rename source mapping.
// Register 0 reads as zero and ignores every write.
module regfile_rat #(
    parameter  int XLEN         = 32,
    parameter  int NUM_REGS     = 32,
    parameter  int NUM_RD_PORTS = 2,
    parameter  int TAG_W        = 3,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD_PORTS*AW-1:0]    rd_addr,
    output logic [NUM_RD_PORTS*XLEN-1:0]  rd_data,
    output logic [NUM_RD_PORTS-1:0]       rd_busy,
    output logic [NUM_RD_PORTS*TAG_W-1:0] rd_tag,
    input  logic                          disp_valid,
    input  logic [AW-1:0]                 disp_rd,
    input  logic [TAG_W-1:0]              disp_tag,
    input  logic                          commit_valid,
    input  logic [AW-1:0]                 commit_rd,
    input  logic [TAG_W-1:0]              commit_tag,
    input  logic [XLEN-1:0]               commit_data,
    input  logic                          flush
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [TAG_W-1:0]    tags [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Per-register strobes; bit 0 stays low so x0 never changes state.
    logic [NUM_REGS-1:0] disp_hit;
    logic [NUM_REGS-1:0] clr_hit;

    // Decode which register is renamed and which one retires its own producer.
    always_comb begin
        disp_hit = '0;
        clr_hit  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            disp_hit[i] = disp_valid && !flush && (disp_rd == AW'(i));
            clr_hit[i]  = commit_valid && (commit_rd == AW'(i)) && busy[i]
                          && (tags[i] == commit_tag);
        end
    end

    // Committed values: the ROB retires in order, so the write is unconditional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_valid && (commit_rd != '0)) begin
            regs[commit_rd] <= commit_data;
        end
    end

    // Rename state: flush drops everything, a rename beats a retirement clear.
    // Tags are left stale on flush; they carry no meaning while busy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tags[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (disp_hit[i]) begin
                    busy[i] <= 1'b1;
                    tags[i] <= disp_tag;
                end else if (clr_hit[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read ports: x0 is constant zero; a retiring value is forwarded write-first
    // and clears busy in the same cycle when it retires the current producer.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          cm_hit;

        assign addr   = rd_addr[p*AW +: AW];
        assign cm_hit = commit_valid && (commit_rd == addr);

        assign rd_data[p*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         cm_hit       ? commit_data : regs[addr];
        assign rd_busy[p]              = (addr != '0) && busy[addr]
                                         && !(cm_hit && (tags[addr] == commit_tag));
        assign rd_tag[p*TAG_W +: TAG_W] = (addr == '0) ? '0 : tags[addr];
    end

endmodule
